// File: rtl/mmc_chan_cmd_sched_pkg.sv
// Shared definitions for the per-channel DRAM command scheduler: command
// encodings, FSM state enumeration and default timing constants.
package mmc_chan_cmd_sched_pkg;

  localparam logic [1:0] MGR_DRAM_CMD_PC = 2'b00;
  localparam logic [1:0] MGR_DRAM_CMD_PO = 2'b01;
  localparam logic [1:0] MGR_DRAM_CMD_RD = 2'b10;
  localparam logic [1:0] MGR_DRAM_CMD_WR = 2'b11;

  localparam int DEF_T_ACT2RW = 4;
  localparam int DEF_T_RW2RW  = 2;
  localparam int DEF_T_PC2ACT = 3;

  // Wide enough for any of the spacing constants above.
  localparam int TCNT_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CLOSE  = 2'd1,
    OPEN   = 2'd2,
    ACCESS = 2'd3
  } sched_state_t;

  // Reload value for a spacing of t cycles (counter expires at zero).
  function automatic logic [TCNT_W-1:0] tload(input int t);
    return (t > 1) ? TCNT_W'(t - 1) : {TCNT_W{1'b0}};
  endfunction

endpackage

// File: rtl/mmc_bank_state.sv
// One bank of the open-page table: open bit, open page and the per-bank
// PO->access / PC->PO spacing down-counter.
module mmc_bank_state
  import mmc_chan_cmd_sched_pkg::*;
#(
  parameter int PAGE_W   = 12,
  parameter int T_ACT2RW = DEF_T_ACT2RW,
  parameter int T_PC2ACT = DEF_T_PC2ACT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              po,
  input  logic              pc,
  input  logic [PAGE_W-1:0] page_in,
  output logic              is_open,
  output logic [PAGE_W-1:0] page,
  output logic              expired
);

  logic [TCNT_W-1:0] cnt;

  // Open/close tracking and saturating spacing counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      is_open <= 1'b0;
      page    <= {PAGE_W{1'b0}};
      cnt     <= {TCNT_W{1'b0}};
    end else if (po) begin
      is_open <= 1'b1;
      page    <= page_in;
      cnt     <= tload(T_ACT2RW);
    end else if (pc) begin
      is_open <= 1'b0;
      cnt     <= tload(T_PC2ACT);
    end else if (cnt != {TCNT_W{1'b0}}) begin
      cnt <= cnt - TCNT_W'(1);
    end
  end

  assign expired = (cnt == {TCNT_W{1'b0}});

endmodule

// File: rtl/mmc_chan_cmd_sched.sv
// Per-channel DRAM command scheduler. Define MGR_MMC_SCHED_CLOSED_PAGE_EN to
// close the page after every access (closed-page policy); default is open-page.
module mmc_chan_cmd_sched
  import mmc_chan_cmd_sched_pkg::*;
#(
  parameter int NUM_BANKS  = 32,
  parameter int BANK_W     = 5,
  parameter int PAGE_W     = 12,
  parameter int LINE_W     = 6,
  parameter int PHY_ADDR_W = 12,
  parameter int T_ACT2RW   = DEF_T_ACT2RW,
  parameter int T_RW2RW    = DEF_T_RW2RW,
  parameter int T_PC2ACT   = DEF_T_PC2ACT
) (
  input  logic                  clk,
  input  logic                  reset_poweron,
  input  logic                  dfi__mmc__init_done,
  input  logic                  req__sched__valid,
  output logic                  sched__req__ready,
  input  logic                  req__sched__wr,
  input  logic [BANK_W-1:0]     req__sched__bank,
  input  logic [PAGE_W-1:0]     req__sched__page,
  input  logic [LINE_W-1:0]     req__sched__line,
  output logic                  mmc__dfi__cs,
  output logic                  mmc__dfi__cmd1,
  output logic                  mmc__dfi__cmd0,
  output logic [BANK_W-1:0]     mmc__dfi__bank,
  output logic [PHY_ADDR_W-1:0] mmc__dfi__addr,
  output logic                  sched__wr_issue,
  output logic                  sched__rd_issue
);

  sched_state_t state, state_nxt;

  logic                  cap_wr;
  logic [BANK_W-1:0]     cap_bank;
  logic [PAGE_W-1:0]     cap_page;
  logic [LINE_W-1:0]     cap_line;
  logic [TCNT_W-1:0]     rw_cnt;
  logic [NUM_BANKS-1:0]  bank_open, bank_expired, bank_po, bank_pc;
  logic [PAGE_W-1:0]     bank_page [NUM_BANKS];
  logic [BANK_W-1:0]     sel_bank;
  logic                  accept, issue, po_cmd, pc_cmd, rw_cmd;
  logic [1:0]            cmd_nxt;
  logic [PHY_ADDR_W-1:0] addr_nxt;

  for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
    mmc_bank_state #(
      .PAGE_W  (PAGE_W),
      .T_ACT2RW(T_ACT2RW),
      .T_PC2ACT(T_PC2ACT)
    ) u_bank (
      .clk    (clk),
      .rst    (reset_poweron),
      .po     (bank_po[g]),
      .pc     (bank_pc[g]),
      .page_in(cap_page),
      .is_open(bank_open[g]),
      .page   (bank_page[g]),
      .expired(bank_expired[g])
    );
  end

  assign accept   = req__sched__valid & sched__req__ready;
  // While idle the table is looked up with the incoming request's bank.
  assign sel_bank = (state == IDLE) ? req__sched__bank : cap_bank;

  // Next-state and command selection.
  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    po_cmd    = 1'b0;
    pc_cmd    = 1'b0;
    rw_cmd    = 1'b0;
    cmd_nxt   = MGR_DRAM_CMD_PC;
    addr_nxt  = {PHY_ADDR_W{1'b0}};
    case (state)
      IDLE: begin
        if (!accept) begin
          state_nxt = IDLE;
        end else if (!bank_open[sel_bank]) begin
          state_nxt = OPEN;
        end else if (bank_page[sel_bank] == req__sched__page) begin
          state_nxt = ACCESS;
        end else begin
          state_nxt = CLOSE;
        end
      end
      CLOSE: begin
        if (dfi__mmc__init_done && bank_expired[sel_bank]) begin
          issue  = 1'b1;
          pc_cmd = 1'b1;
`ifdef MGR_MMC_SCHED_CLOSED_PAGE_EN
          state_nxt = IDLE;
`else
          state_nxt = OPEN;
`endif
        end else begin
          state_nxt = CLOSE;
        end
      end
      OPEN: begin
        if (dfi__mmc__init_done && bank_expired[sel_bank]) begin
          issue     = 1'b1;
          po_cmd    = 1'b1;
          cmd_nxt   = MGR_DRAM_CMD_PO;
          addr_nxt  = PHY_ADDR_W'(cap_page);
          state_nxt = ACCESS;
        end else begin
          state_nxt = OPEN;
        end
      end
      ACCESS: begin
        if (dfi__mmc__init_done && bank_expired[sel_bank] &&
            (rw_cnt == {TCNT_W{1'b0}})) begin
          issue    = 1'b1;
          rw_cmd   = 1'b1;
          cmd_nxt  = cap_wr ? MGR_DRAM_CMD_WR : MGR_DRAM_CMD_RD;
          addr_nxt = PHY_ADDR_W'(cap_line);
`ifdef MGR_MMC_SCHED_CLOSED_PAGE_EN
          state_nxt = CLOSE;
`else
          state_nxt = IDLE;
`endif
        end else begin
          state_nxt = ACCESS;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // One-hot update strobes into the bank table.
  always_comb begin
    bank_po           = {NUM_BANKS{1'b0}};
    bank_pc           = {NUM_BANKS{1'b0}};
    bank_po[cap_bank] = po_cmd;
    bank_pc[cap_bank] = pc_cmd;
  end

  // FSM state, captured request and global access-spacing counter.
  always_ff @(posedge clk or posedge reset_poweron) begin
    if (reset_poweron) begin
      state    <= IDLE;
      cap_wr   <= 1'b0;
      cap_bank <= {BANK_W{1'b0}};
      cap_page <= {PAGE_W{1'b0}};
      cap_line <= {LINE_W{1'b0}};
      rw_cnt   <= {TCNT_W{1'b0}};
    end else begin
      state <= state_nxt;
      if (accept) begin
        cap_wr   <= req__sched__wr;
        cap_bank <= req__sched__bank;
        cap_page <= req__sched__page;
        cap_line <= req__sched__line;
      end
      if (rw_cmd) begin
        rw_cnt <= tload(T_RW2RW);
      end else if (rw_cnt != {TCNT_W{1'b0}}) begin
        rw_cnt <= rw_cnt - TCNT_W'(1);
      end
    end
  end

  // Registered command bus; every field is zero on a NOP cycle.
  always_ff @(posedge clk or posedge reset_poweron) begin
    if (reset_poweron) begin
      mmc__dfi__cs      <= 1'b0;
      mmc__dfi__cmd1    <= 1'b0;
      mmc__dfi__cmd0    <= 1'b0;
      mmc__dfi__bank    <= {BANK_W{1'b0}};
      mmc__dfi__addr    <= {PHY_ADDR_W{1'b0}};
      sched__wr_issue   <= 1'b0;
      sched__rd_issue   <= 1'b0;
      sched__req__ready <= 1'b0;
    end else begin
      mmc__dfi__cs      <= issue;
      mmc__dfi__cmd1    <= cmd_nxt[1];
      mmc__dfi__cmd0    <= cmd_nxt[0];
      mmc__dfi__bank    <= issue ? cap_bank : {BANK_W{1'b0}};
      mmc__dfi__addr    <= addr_nxt;
      sched__wr_issue   <= rw_cmd & cap_wr;
      sched__rd_issue   <= rw_cmd & ~cap_wr;
      sched__req__ready <= (state_nxt == IDLE) & dfi__mmc__init_done;
    end
  end

endmodule

// File: tb/tb_mmc_chan_cmd_sched.sv
// Directed self-checking bench for mmc_chan_cmd_sched (default open-page build;
// the closed-page sequence is used when MGR_MMC_SCHED_CLOSED_PAGE_EN is defined).
module tb_mmc_chan_cmd_sched;

  localparam logic [1:0] C_PC = 2'b00;
  localparam logic [1:0] C_PO = 2'b01;
  localparam logic [1:0] C_RD = 2'b10;
  localparam logic [1:0] C_WR = 2'b11;

  logic        clk = 1'b0;
  logic        reset_poweron;
  logic        dfi__mmc__init_done;
  logic        req__sched__valid;
  logic        sched__req__ready;
  logic        req__sched__wr;
  logic [4:0]  req__sched__bank;
  logic [11:0] req__sched__page;
  logic [5:0]  req__sched__line;
  logic        mmc__dfi__cs, mmc__dfi__cmd1, mmc__dfi__cmd0;
  logic [4:0]  mmc__dfi__bank;
  logic [11:0] mmc__dfi__addr;
  logic        sched__wr_issue, sched__rd_issue;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int cmd_cyc = 0;
  int prev_cyc = 0;
  int seen;

  mmc_chan_cmd_sched dut (
    .clk                (clk),
    .reset_poweron      (reset_poweron),
    .dfi__mmc__init_done(dfi__mmc__init_done),
    .req__sched__valid  (req__sched__valid),
    .sched__req__ready  (sched__req__ready),
    .req__sched__wr     (req__sched__wr),
    .req__sched__bank   (req__sched__bank),
    .req__sched__page   (req__sched__page),
    .req__sched__line   (req__sched__line),
    .mmc__dfi__cs       (mmc__dfi__cs),
    .mmc__dfi__cmd1     (mmc__dfi__cmd1),
    .mmc__dfi__cmd0     (mmc__dfi__cmd0),
    .mmc__dfi__bank     (mmc__dfi__bank),
    .mmc__dfi__addr     (mmc__dfi__addr),
    .sched__wr_issue    (sched__wr_issue),
    .sched__rd_issue    (sched__rd_issue)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_bus(input string tag);
    chk({tag, "_nop"}, {mmc__dfi__cs, mmc__dfi__cmd1, mmc__dfi__cmd0, mmc__dfi__bank,
                        mmc__dfi__addr, sched__wr_issue, sched__rd_issue}, 32'h0);
  endtask

  // Present a request, wait (bounded) for ready, then clock the accept edge.
  task automatic send(input logic wr, input logic [4:0] b, input logic [11:0] p,
                      input logic [5:0] l);
    int k = 0;
    req__sched__valid = 1'b1;
    req__sched__wr    = wr;
    req__sched__bank  = b;
    req__sched__page  = p;
    req__sched__line  = l;
    while (!sched__req__ready && k < 40) begin
      tick();
      k++;
    end
    chk("ready_wait", {31'h0, k < 40}, 32'h1);
    tick();
    req__sched__valid = 1'b0;
  endtask

  // Wait (bounded) for the next command strobe and check delay and fields.
  task automatic expect_cmd(input string tag, input logic [1:0] c, input logic [4:0] b,
                            input logic [11:0] a, input int dly, input logic wr_p,
                            input logic rd_p);
    int k = 0;
    do begin
      tick();
      k++;
    end while (!mmc__dfi__cs && k < 40);
    prev_cyc = cmd_cyc;
    cmd_cyc  = cyc;
    chk({tag, "_dly"}, k, dly);
    chk({tag, "_cmd"}, {mmc__dfi__cmd1, mmc__dfi__cmd0}, c);
    chk({tag, "_bank"}, mmc__dfi__bank, b);
    chk({tag, "_addr"}, mmc__dfi__addr, a);
    chk({tag, "_pulse"}, {sched__wr_issue, sched__rd_issue}, {wr_p, rd_p});
  endtask

  initial begin
    reset_poweron       = 1'b1;
    dfi__mmc__init_done = 1'b0;
    req__sched__valid   = 1'b0;
    req__sched__wr      = 1'b0;
    req__sched__bank    = 5'd0;
    req__sched__page    = 12'h0;
    req__sched__line    = 6'd0;
    tick();
    tick();
    chk_idle_bus("reset");
    chk("reset_ready", sched__req__ready, 1'b0);
    reset_poweron = 1'b0;

    // Request while init_done is low: must not be accepted nor issue.
    req__sched__valid = 1'b1;
    req__sched__bank  = 5'd3;
    req__sched__page  = 12'h012;
    req__sched__line  = 6'd5;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      seen += int'(sched__req__ready) + int'(mmc__dfi__cs);
    end
    chk("no_init_quiet", seen, 0);
    dfi__mmc__init_done = 1'b1;
    tick();
    chk("init_ready", sched__req__ready, 1'b1);

`ifdef MGR_MMC_SCHED_CLOSED_PAGE_EN
    send(1'b0, 5'd3, 12'h012, 6'd5);
    expect_cmd("cp1_po", C_PO, 5'd3, 12'h012, 1, 1'b0, 1'b0);
    expect_cmd("cp1_rd", C_RD, 5'd3, 12'h005, 4, 1'b0, 1'b1);
    expect_cmd("cp1_pc", C_PC, 5'd3, 12'h000, 1, 1'b0, 1'b0);
    send(1'b0, 5'd3, 12'h012, 6'd6);
    expect_cmd("cp2_po", C_PO, 5'd3, 12'h012, 2, 1'b0, 1'b0);
    expect_cmd("cp2_rd", C_RD, 5'd3, 12'h006, 4, 1'b0, 1'b1);
    expect_cmd("cp2_pc", C_PC, 5'd3, 12'h000, 1, 1'b0, 1'b0);
`else
    // Cold miss: PO then RD exactly T_ACT2RW later.
    send(1'b0, 5'd3, 12'h012, 6'd5);
    chk("accept_drops_ready", sched__req__ready, 1'b0);
    expect_cmd("miss_po", C_PO, 5'd3, 12'h012, 1, 1'b0, 1'b0);
    expect_cmd("miss_rd", C_RD, 5'd3, 12'h005, 4, 1'b0, 1'b1);
    chk("ready_after_rd", sched__req__ready, 1'b1);
    tick();
    chk_idle_bus("after_rd");

    // Hits: no PO; back-to-back hits spaced by T_RW2RW.
    send(1'b0, 5'd3, 12'h012, 6'd7);
    expect_cmd("hit_rd", C_RD, 5'd3, 12'h007, 1, 1'b0, 1'b1);
    chk("hit_rd_spacing", {31'h0, (cmd_cyc - prev_cyc) >= 2}, 32'h1);
    send(1'b1, 5'd3, 12'h012, 6'd9);
    expect_cmd("hit_wr", C_WR, 5'd3, 12'h009, 1, 1'b1, 1'b0);
    chk("b2b_spacing", cmd_cyc - prev_cyc, 2);

    // Conflict: PC, PO 3 cycles later, WR 4 cycles after that.
    send(1'b1, 5'd3, 12'h020, 6'd3);
    expect_cmd("conf_pc", C_PC, 5'd3, 12'h000, 1, 1'b0, 1'b0);
    expect_cmd("conf_po", C_PO, 5'd3, 12'h020, 3, 1'b0, 1'b0);
    expect_cmd("conf_wr", C_WR, 5'd3, 12'h003, 4, 1'b1, 1'b0);
    tick();
    chk_idle_bus("after_wr");

    // init_done drop while waiting to open: nothing issues until it returns.
    send(1'b1, 5'd7, 12'h001, 6'd2);
    dfi__mmc__init_done = 1'b0;
    seen = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      seen += int'(mmc__dfi__cs);
    end
    chk("init_drop_hold", seen, 0);
    dfi__mmc__init_done = 1'b1;
    expect_cmd("resume_po", C_PO, 5'd7, 12'h001, 1, 1'b0, 1'b0);
    expect_cmd("resume_wr", C_WR, 5'd7, 12'h002, 4, 1'b1, 1'b0);

    // Reset while in OPEN, then bank 3 page 0x20 must be a miss again.
    send(1'b0, 5'd5, 12'h007, 6'd1);
    reset_poweron = 1'b1;
    #1;
    chk_idle_bus("mid_reset");
    chk("mid_reset_ready", sched__req__ready, 1'b0);
    tick();
    tick();
    reset_poweron = 1'b0;
    tick();
    send(1'b0, 5'd3, 12'h020, 6'd4);
    expect_cmd("post_rst_po", C_PO, 5'd3, 12'h020, 1, 1'b0, 1'b0);
    expect_cmd("post_rst_rd", C_RD, 5'd3, 12'h004, 4, 1'b0, 1'b1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
